// File: rtl/pattern_seq_tx_pkg.sv
// rtl/pattern_seq_tx_pkg.sv - shared state encoding, LFSR constants and step function
package pattern_seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    PAT  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // x^8 + x^6 + x^5 + x^4 + 1 on a right-shifting register: stage k carries x^(8-k)
  localparam logic [7:0] LFSR_TAPS    = 8'h1D;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  // Wide enough for gap-1 (max 14) and PAT_W-1 (max 15)
  localparam int CNT_W = 4;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {^(q & LFSR_TAPS), q[7:1]};
  endfunction

endpackage

// File: rtl/pattern_seq_tx_lfsr8.sv
// rtl/pattern_seq_tx_lfsr8.sv - 8-bit Fibonacci LFSR, reset/reload to seed, advances on en
module lfsr8
  import pattern_seq_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= seed;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/pattern_seq_tx.sv
// rtl/pattern_seq_tx.sv - framed serial pattern transmitter: fill bits then PATTERN, MSB first
module pattern_seq_tx
  import pattern_seq_tx_pkg::*;
#(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] PATTERN   = 4'b1011,
  parameter logic [7:0]       LFSR_SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] count,
  input  logic [3:0] gap,
  input  logic       fill_mode,
  input  logic       fill_bit,
  output logic       out,
  output logic       out_valid,
  output logic       mark,
  output logic       busy,
  output logic       done
);

  localparam logic [PAT_W-1:0] BIT0 = {{(PAT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [7:0]       remaining, remaining_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       gap_q;
  logic             fill_mode_q, fill_bit_q;
  logic             fm_eff, fb_eff;
  logic             lfsr_en;
  logic [7:0]       lfsr_q;
  logic             out_nxt, mark_nxt, valid_nxt;
  logic             accept;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (1'b0),
    .en   (lfsr_en),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign accept = (state == IDLE) && start;

  // cnt indexes the bit being emitted within the current phase, counting down to 0
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    cnt_nxt       = cnt;
    fm_eff        = fill_mode_q;
    fb_eff        = fill_bit_q;

    case (state)
      IDLE: begin
        if (start) begin
          fm_eff        = fill_mode;
          fb_eff        = fill_bit;
          remaining_nxt = count;
          if (count == 8'd0) begin
            state_nxt = FIN;
          end else if (gap != 4'd0) begin
            state_nxt = GAP;
            cnt_nxt   = CNT_W'(gap - 4'd1);
          end else begin
            state_nxt = PAT;
            cnt_nxt   = CNT_W'(PAT_W - 1);
          end
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = PAT;
          cnt_nxt   = CNT_W'(PAT_W - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      PAT: begin
        if (cnt == '0) begin
          remaining_nxt = remaining - 8'd1;
          if (remaining == 8'd1) begin
            state_nxt = FIN;
          end else if (gap_q != 4'd0) begin
            state_nxt = GAP;
            cnt_nxt   = CNT_W'(gap_q - 4'd1);
          end else begin
            state_nxt = PAT;
            cnt_nxt   = CNT_W'(PAT_W - 1);
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs are precomputed for the bit that the next state will present
    valid_nxt = (state_nxt == GAP) || (state_nxt == PAT);
    lfsr_en   = (state_nxt == GAP) && fm_eff;
    out_nxt   = 1'b0;
    mark_nxt  = 1'b0;
    if (state_nxt == GAP) begin
      out_nxt = fm_eff ? lfsr_q[0] : fb_eff;
    end else if (state_nxt == PAT) begin
      out_nxt  = |(PATTERN & (BIT0 << cnt_nxt));
      mark_nxt = (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      remaining   <= 8'd0;
      cnt         <= '0;
      gap_q       <= 4'd0;
      fill_mode_q <= 1'b0;
      fill_bit_q  <= 1'b0;
      out         <= 1'b0;
      out_valid   <= 1'b0;
      mark        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      cnt       <= cnt_nxt;
      if (accept) begin
        gap_q       <= gap;
        fill_mode_q <= fill_mode;
        fill_bit_q  <= fill_bit;
      end
      out       <= out_nxt;
      out_valid <= valid_nxt;
      mark      <= mark_nxt;
      busy      <= valid_nxt;
      done      <= (state_nxt == FIN);
    end
  end

  // A nonzero seed can never reach the all-zero lock-up state
  lfsr_nonzero: assert property (@(posedge clk) disable iff (!rst) lfsr_q != 8'd0);

endmodule

// File: doc/pattern_seq_tx.md
Name: pattern_seq_tx

Overview:
Serial pattern-stream transmitter. It is the source end of the serial bit-stream interface consumed by the Mealy pattern detectors.
- Emits frames of fill bits followed by a fixed PAT_W-bit pattern, MSB first.
- Raises a mark flag on the last bit of each inserted pattern, so a downstream detector's output can be checked cycle-by-cycle.
- Used as stimulus source in detector benches and as a synthesizable test-pattern generator.

Parameters:
PAT_W, 4, pattern length in bits (2..16)
PATTERN, 4'b1011, pattern value, transmitted MSB first
LFSR_SEED, 8'hA5, nonzero reset/reload seed of the fill LFSR

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-low (rst=0 resets)
start  input  1  one-cycle request to begin a burst; sampled only in IDLE
count  input  8  number of patterns in burst; latched on accepted start
gap  input  4  fill bits before each pattern; latched on accepted start
fill_mode  input  1  0 = constant fill_bit, 1 = LFSR fill; latched on start
fill_bit  input  1  constant fill value; latched on start
out  output  1  serial data bit
out_valid  output  1  out carries a stream bit this cycle
mark  output  1  high on the final bit of each pattern
busy  output  1  burst in progress
done  output  1  one-cycle pulse after the final bit of a burst

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous):
  - out, out_valid, mark, busy and done go to 0.
  - State returns to IDLE and the LFSR reloads LFSR_SEED.
  - Holds until rst=1; after release, stays in IDLE until a new start.
- States: IDLE, GAP, PAT, FIN.
- IDLE:
  - start=1 latches count, gap, fill_mode and fill_bit.
  - count=0: go to FIN.
  - Otherwise go to GAP if gap!=0, else PAT. Load the pattern counter with remaining=count and the bit counter.
- Latency: start accepted on cycle k → first stream bit (out_valid=1, busy=1) on cycle k+1.
- GAP:
  - Emits exactly gap fill bits, one per cycle.
  - fill_mode=0: out=fill_bit.
  - fill_mode=1: out=lfsr[0]. The LFSR advances once per emitted fill bit only.
  - After the last fill bit, go to PAT.
- PAT:
  - Emits PATTERN[PAT_W-1] down to PATTERN[0], one per cycle.
  - mark=1 only on the PATTERN[0] cycle.
  - After the last bit, decrement remaining. If remaining is nonzero, go to GAP (or PAT when gap=0); otherwise go to FIN.
  - With gap=0, patterns are back-to-back with no idle cycle.
- FIN:
  - Drives out_valid=0, busy=0, done=1 for exactly one cycle, then returns to IDLE.
  - Burst length is count*(gap+PAT_W) stream cycles; done lands on the cycle after the last bit.
- When out_valid=0, out is driven 0 and mark is 0.
- start while busy or in FIN is ignored; it is not queued.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifting right.
  - Not reseeded between bursts, only on reset.
  - An all-zero state is unreachable from a nonzero seed.
- Counters: remaining is 8-bit, bit counter sized for max(gap, PAT_W). No wrap-around is possible because loads are bounded by the inputs.
- mark is only a meaningful detector reference when the fill cannot form the pattern. Benches use constant fill for detector checking.

Decomposition:
- Shared package/include: state encoding localparams (IDLE, GAP, PAT, FIN), LFSR tap mask, default seed.
- One sub-module: lfsr8. Ports: clk, rst, load, en, seed, q[7:0]. Async active-low reset to seed; advances on en. It is reused by future stimulus generators.

Test Plan:
1. rst=0 mid-idle with random inputs → out=0, out_valid=0, mark=0, busy=0, done=0 immediately (asynchronous, no clock edge needed).
2. count=1, gap=0, start pulse at cycle k → out = 1,0,1,1 on cycles k+1..k+4 with out_valid=1; mark only at k+4; done=1 at k+5 only; busy falls at k+5.
3. count=3, gap=2, fill_mode=0, fill_bit=0 → 18-bit stream 00 1011 00 1011 00 1011; mark on stream bits 6, 12 and 18; a connected non-overlapping detector's out matches mark exactly.
4. count=0 with start → no out_valid cycle; done=1 on cycle k+1; busy stays 0.
5. start reasserted during a burst and on the FIN cycle → ignored, burst length unchanged; start on the cycle after done → new burst accepted and count/gap reloaded.
6. fill_mode=1, gap=8, count=1, rst pulsed mid-pattern, then the same burst repeated twice → out_valid drops asynchronously; first post-reset burst's 8 fill bits equal the LFSR sequence from 8'hA5; second burst continues the sequence rather than repeating it.
